// File: rtl/equalizer_cmul_pipe_pkg.sv
// Shared widths and width helpers for the equalizer complex multiplier.
// Default stream/coefficient geometry plus product and sum sizing.
package equalizer_cmul_pipe_pkg;

    localparam int DIN_W_DEF  = 16;
    localparam int COEF_W_DEF = 16;
    localparam int DOUT_W_DEF = 16;
    localparam int SHIFT_DEF  = 15;
    localparam int TAG_W_DEF  = 8;

    function automatic int prod_w(input int din_w, input int coef_w);
        return din_w + coef_w;
    endfunction

    // One guard bit so rr+ii of two full-scale products cannot wrap
    function automatic int sum_w(input int din_w, input int coef_w);
        return din_w + coef_w + 1;
    endfunction

endpackage

// File: rtl/equalizer_cmul_rndsat.sv
// Round-half-up, arithmetic shift and saturate for one product rail.
// Returns the narrowed value and a flag when clipping occurred.
module equalizer_cmul_rndsat #(
    parameter int SUM_W  = 33,
    parameter int DOUT_W = 16,
    parameter int SHIFT  = 15
) (
    input  logic [SUM_W-1:0]  x_i,
    output logic [DOUT_W-1:0] y_o,
    output logic              sat_o
);

    localparam int W   = SUM_W + 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [W-1:0] RND =
        (SHIFT > 0) ? ({{(W-1){1'b0}}, 1'b1} << RSH) : '0;

    localparam logic signed [W-1:0] MAXV =
        {{(W-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
    localparam logic signed [W-1:0] MINV =
        {{(W-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

    logic        [W-1:0] ext;
    logic signed [W-1:0] sh;

    assign ext = {x_i[SUM_W-1], x_i} + RND;
    assign sh  = $signed(ext) >>> SHIFT;

    always_comb begin
        y_o   = sh[DOUT_W-1:0];
        sat_o = 1'b0;
        if (sh > MAXV) begin
            y_o   = MAXV[DOUT_W-1:0];
            sat_o = 1'b1;
        end else if (sh < MINV) begin
            y_o   = MINV[DOUT_W-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/equalizer_cmul_pipe.sv
// Four-stage complex multiplier y = a*b or a*conj(b) with rounding,
// saturation, tag passthrough and a stall-all valid/ready handshake.
module equalizer_cmul_pipe
    import equalizer_cmul_pipe_pkg::*;
#(
    parameter int DIN_W  = DIN_W_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int DOUT_W = DOUT_W_DEF,
    parameter int SHIFT  = SHIFT_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_conj,
    input  logic [DIN_W-1:0]  a_re,
    input  logic [DIN_W-1:0]  a_im,
    input  logic [COEF_W-1:0] b_re,
    input  logic [COEF_W-1:0] b_im,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DOUT_W-1:0] y_re,
    output logic [DOUT_W-1:0] y_im,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_sat
);

    localparam int PROD_W = prod_w(DIN_W, COEF_W);
    localparam int SUM_W  = sum_w(DIN_W, COEF_W);

    logic adv;

    logic              s1_v_q, s1_conj_q;
    logic [DIN_W-1:0]  s1_are_q, s1_aim_q;
    logic [COEF_W-1:0] s1_bre_q, s1_bim_q;
    logic [TAG_W-1:0]  s1_tag_q;

    logic                     s2_v_q, s2_conj_q;
    logic signed [PROD_W-1:0] rr_q, ii_q, ir_q, ri_q;
    logic signed [PROD_W-1:0] rr_d, ii_d, ir_d, ri_d;
    logic [TAG_W-1:0]         s2_tag_q;

    logic                    s3_v_q;
    logic signed [SUM_W-1:0] rr_x, ii_x, ir_x, ri_x;
    logic signed [SUM_W-1:0] re_q, im_q, re_d, im_d;
    logic [TAG_W-1:0]        s3_tag_q;

    logic              out_v_q, sat_q;
    logic [DOUT_W-1:0] yre_q, yim_q, yre_d, yim_d;
    logic [TAG_W-1:0]  tag_q;
    logic              sat_re, sat_im;

    assign adv      = ~out_v_q | out_ready;
    assign in_ready = adv & ~reset;

    // Plain signed multiplies so synthesis maps them onto DSP slices
    assign rr_d = PROD_W'($signed(s1_are_q)) * PROD_W'($signed(s1_bre_q));
    assign ii_d = PROD_W'($signed(s1_aim_q)) * PROD_W'($signed(s1_bim_q));
    assign ir_d = PROD_W'($signed(s1_aim_q)) * PROD_W'($signed(s1_bre_q));
    assign ri_d = PROD_W'($signed(s1_are_q)) * PROD_W'($signed(s1_bim_q));

    assign rr_x = {rr_q[PROD_W-1], rr_q};
    assign ii_x = {ii_q[PROD_W-1], ii_q};
    assign ir_x = {ir_q[PROD_W-1], ir_q};
    assign ri_x = {ri_q[PROD_W-1], ri_q};

    assign re_d = s2_conj_q ? rr_x + ii_x : rr_x - ii_x;
    assign im_d = s2_conj_q ? ir_x - ri_x : ir_x + ri_x;

    equalizer_cmul_rndsat #(
        .SUM_W (SUM_W),
        .DOUT_W(DOUT_W),
        .SHIFT (SHIFT)
    ) u_rs_re (
        .x_i  (re_q),
        .y_o  (yre_d),
        .sat_o(sat_re)
    );

    equalizer_cmul_rndsat #(
        .SUM_W (SUM_W),
        .DOUT_W(DOUT_W),
        .SHIFT (SHIFT)
    ) u_rs_im (
        .x_i  (im_q),
        .y_o  (yim_d),
        .sat_o(sat_im)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q  <= 1'b0;
            s2_v_q  <= 1'b0;
            s3_v_q  <= 1'b0;
            out_v_q <= 1'b0;
            yre_q   <= '0;
            yim_q   <= '0;
            tag_q   <= '0;
            sat_q   <= 1'b0;
        end else if (adv) begin
            s1_v_q    <= in_valid;
            s1_conj_q <= in_conj;
            s1_are_q  <= a_re;
            s1_aim_q  <= a_im;
            s1_bre_q  <= b_re;
            s1_bim_q  <= b_im;
            s1_tag_q  <= in_tag;

            s2_v_q    <= s1_v_q;
            s2_conj_q <= s1_conj_q;
            s2_tag_q  <= s1_tag_q;
            rr_q      <= rr_d;
            ii_q      <= ii_d;
            ir_q      <= ir_d;
            ri_q      <= ri_d;

            s3_v_q    <= s2_v_q;
            s3_tag_q  <= s2_tag_q;
            re_q      <= re_d;
            im_q      <= im_d;

            out_v_q   <= s3_v_q;
            yre_q     <= yre_d;
            yim_q     <= yim_d;
            tag_q     <= s3_tag_q;
            sat_q     <= s3_v_q & (sat_re | sat_im);
        end
    end

    assign out_valid = out_v_q;
    assign y_re      = yre_q;
    assign y_im      = yim_q;
    assign out_tag   = tag_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_equalizer_cmul_pipe.sv
// Directed-vector and streaming bench for equalizer_cmul_pipe.
// Expected values are hand-computed or come from a small behavioural model.
module tb_equalizer_cmul_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_conj;
    logic [15:0] a_re, a_im, b_re, b_im;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y_re, y_im;
    logic [7:0]  out_tag;
    logic        out_sat;

    int checks = 0;
    int errors = 0;

    equalizer_cmul_pipe dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_conj  (in_conj),
        .a_re     (a_re),
        .a_im     (a_im),
        .b_re     (b_re),
        .b_im     (b_im),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y_re     (y_re),
        .y_im     (y_im),
        .out_tag  (out_tag),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic conj;
        int   ar, ai, br, bi;
        int   ere, eim, esat;
    } vec_t;

    typedef struct {
        int re, im, tag, sat;
    } exp_t;

    vec_t vt[13];
    exp_t sb[$];

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input int ar, input int ai,
                         input int br, input int bi, input int tag);
        in_conj = c;
        a_re    = 16'(ar);
        a_im    = 16'(ai);
        b_re    = 16'(br);
        b_im    = 16'(bi);
        in_tag  = 8'(tag);
    endtask

    function automatic int rs(input longint v, output int sat);
        longint t;
        t   = (v + 64'sd16384) >>> 15;
        sat = 0;
        if (t > 32767) begin
            t   = 32767;
            sat = 1;
        end else if (t < -32768) begin
            t   = -32768;
            sat = 1;
        end
        return int'(t);
    endfunction

    function automatic exp_t model(input logic c, input int ar, input int ai,
                                   input int br, input int bi, input int tag);
        exp_t   e;
        longint rr, ii, ir, ri, re, im;
        int     s1, s2;
        rr = longint'(ar) * br;
        ii = longint'(ai) * bi;
        ir = longint'(ai) * br;
        ri = longint'(ar) * bi;
        re = c ? rr + ii : rr - ii;
        im = c ? ir - ri : ir + ri;
        e.re  = rs(re, s1);
        e.im  = rs(im, s2);
        e.sat = s1 | s2;
        e.tag = tag;
        return e;
    endfunction

    initial begin
        int   lat, idx, got, seen;
        bit   saw_stall, hold, acc;
        logic [15:0] p_re, p_im;
        logic [7:0]  p_tag;
        logic        p_sat;
        int   sar[32], sai[32], sbr[32], sbi[32];
        logic sc[32];
        exp_t e;

        vt[0]  = '{1'b0, 16384, 0, 16384, 0, 8192, 0, 0};
        vt[1]  = '{1'b0, 0, 16384, 0, 16384, -8192, 0, 0};
        vt[2]  = '{1'b1, 0, 16384, 0, 16384, 8192, 0, 0};
        vt[3]  = '{1'b0, -32768, -32768, -32768, -32768, 0, 32767, 1};
        vt[4]  = '{1'b0, 1, 0, 16384, 0, 1, 0, 0};
        vt[5]  = '{1'b0, 1, 0, 16383, 0, 0, 0, 0};
        vt[6]  = '{1'b0, -1, 0, 16385, 0, -1, 0, 0};
        vt[7]  = '{1'b1, -32768, -32768, -32768, -32768, 32767, 0, 1};
        vt[8]  = '{1'b0, 0, -32768, 0, -32768, -32768, 0, 0};
        vt[9]  = '{1'b0, -32768, 0, 32767, 0, -32767, 0, 0};
        vt[10] = '{1'b0, 100, 200, 300, -400, 3, 1, 0};
        vt[11] = '{1'b1, 100, 200, 300, -400, -2, 3, 0};
        vt[12] = '{1'b1, -32768, 32767, 32767, -32768, -32768, -2, 1};

        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 0, 0, 0, 0, 0);
        tick();
        tick();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y_re", y_re, 0);
        chk("rst_y_im", y_im, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_sat", out_sat, 0);
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].conj, vt[i].ar, vt[i].ai, vt[i].br, vt[i].bi, i + 16);
            in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                tick();
                lat++;
            end
            chk($sformatf("v%0d_latency", i), lat, 4);
            chk($sformatf("v%0d_y_re", i), $signed(y_re), vt[i].ere);
            chk($sformatf("v%0d_y_im", i), $signed(y_im), vt[i].eim);
            chk($sformatf("v%0d_sat", i), out_sat, vt[i].esat);
            chk($sformatf("v%0d_tag", i), out_tag, i + 16);
            tick();
            chk($sformatf("v%0d_drain", i), out_valid, 0);
        end

        for (int k = 0; k < 32; k++) begin
            sar[k] = int'($urandom_range(0, 65535)) - 32768;
            sai[k] = int'($urandom_range(0, 65535)) - 32768;
            sbr[k] = int'($urandom_range(0, 65535)) - 32768;
            sbi[k] = int'($urandom_range(0, 65535)) - 32768;
            sc[k]  = 1'($urandom_range(0, 1));
        end
        sar[5] = -32768; sai[5] = -32768; sbr[5] = -32768; sbi[5] = -32768;
        sc[5]  = 1'b0;

        idx = 0; got = 0; saw_stall = 0; hold = 0;
        p_re = '0; p_im = '0; p_tag = '0; p_sat = 1'b0;
        for (int cyc = 0; cyc < 600 && got < 32; cyc++) begin
            if (idx < 32) begin
                in_valid = 1'b1;
                drive(sc[idx], sar[idx], sai[idx], sbr[idx], sbi[idx], idx + 100);
            end else begin
                in_valid = 1'b0;
            end
            if (cyc >= 12 && cyc < 22) out_ready = 1'b0;
            else out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("bp_in_ready", in_ready, !out_valid || out_ready);
            if (hold) begin
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_re", y_re, p_re);
                chk("bp_hold_im", y_im, p_im);
                chk("bp_hold_tag", out_tag, p_tag);
                chk("bp_hold_sat", out_sat, p_sat);
            end
            if (in_valid && !in_ready) saw_stall = 1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("bp_unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("bp_y_re", $signed(y_re), e.re);
                    chk("bp_y_im", $signed(y_im), e.im);
                    chk("bp_tag", out_tag, e.tag);
                    chk("bp_sat", out_sat, e.sat);
                end
                got++;
            end
            acc = in_valid && in_ready;
            if (acc)
                sb.push_back(model(sc[idx], sar[idx], sai[idx], sbr[idx],
                                   sbi[idx], idx + 100));
            hold  = out_valid && !out_ready;
            p_re  = y_re;
            p_im  = y_im;
            p_tag = out_tag;
            p_sat = out_sat;
            tick();
            if (acc) idx++;
        end
        chk("bp_count", got, 32);
        chk("bp_stall_seen", saw_stall, 1);
        chk("bp_sb_empty", sb.size(), 0);

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 16384, 0, 16384, 0, 8'hC0 + k);
            in_valid = 1'b1;
            tick();
        end
        drive(1'b0, 16384, 0, 16384, 0, 8'hC3);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 0);
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("mid_rst_ghosts", seen, 0);

        drive(1'b0, 16384, 0, 16384, 0, 8'h5A);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("post_rst_latency", lat, 4);
        chk("post_rst_y_re", $signed(y_re), 8192);
        chk("post_rst_tag", out_tag, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
